dff_sync_rstn: RTL and testbench
================================

// Module: dff_sync_rstn
// PURPOSE
//  - Single-clock D-type register, WIDTH bits wide, with synchronous active-low reset.
//  - Base storage primitive for pipeline and status registers. Replaces separate
//    synchronous-reset and asynchronous-reset flop variants with one sync-reset primitive.
//  - Holds no state other than Q. Has no enable and no handshake.
// PARAMETERS
//  - WIDTH      1     Data width in bits (>=1).
//  - RESET_VAL  '0    Value loaded into Q on reset. WIDTH bits, zero-extended or truncated.
// PORTS
//  - clk    in   1      Clock. All state changes occur on the rising edge.
//  - reset  in   1      Reset, synchronous, active-low. 0 = reset asserted.
//  - D      in   WIDTH  Data input.
//  - Q      out  WIDTH  Registered output. Driven directly from a flop, no combinational path.
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low.
//  - At each rising clk edge:
//      if reset==0  Q <= RESET_VAL
//      else         Q <= D
//  - Reset has priority over D at the same edge.
//  - Q never changes between rising edges. Reset asserted or released mid-cycle has
//    no effect until the next rising edge.
//  - Latency D->Q: one cycle. The D value sampled at edge n appears on Q after edge n.
//  - Reset value of Q: RESET_VAL (default all zeros), from the first rising edge with
//    reset==0 onward.
//  - Before the first reset edge, Q is X in simulation. No initial block is used.
//  - X or Z on reset: Q goes X at that edge. Do not silently pick a branch.
//  - D is sampled only at the edge. Glitches on D between edges are ignored.
//  - Width: D and Q are both exactly WIDTH bits. No sign handling.
// STRUCTURE
//  - Shared package (common_pkg) holds:
//      localparam RST_ACTIVE = 1'b0;
//      typedef for a generic reset-polarity constant, reused by all sync-reset primitives.
//  - One natural sub-module: dff_bit_sync_rstn, a 1-bit cell.
//  - Top-level generate loop instantiates WIDTH cells. Bit i of RESET_VAL feeds the
//    reset value of cell i.
//  - One always block per cell, triggered on posedge clk only. reset must not appear
//    in the sensitivity list.
//  - Include simulation-only assertions:
//      Q == RESET_VAL one edge after a reset==0 sample.
//      Q == $past(D) when reset was 1 at the previous edge.
// TESTING  (clk period 10 ns, rising edges at 5, 15, 25, ...; WIDTH=1, RESET_VAL=0)
//  - Reset hold: reset=0, D=0 at t=0; D=1 at t=10
//      -> Q=0 after edges 5 and 15 (reset overrides D=1).
//  - Release and capture: reset=1, D=0 at t=20; D=1 at t=40
//      -> Q=0 after edge 25, Q=1 after edge 45, Q=1 held through edge 55.
//  - Sync reset assert: Q=1, then reset=0 and D=0 at t=60 (mid-cycle)
//      -> Q stays 1 until edge 65, then Q=0.
//      Q remains 0 at edges 75 and 85 with D=1.
//  - Sync reset release mid-cycle: reset=1 at t=92 with D=1
//      -> Q unchanged until edge 95, then Q=1.
//  - Wide instance: WIDTH=8, RESET_VAL=8'hA5. Reset, then D=8'h3C with reset=1
//      -> Q=8'hA5 after the reset edge, Q=8'h3C one edge later.
//  - Reset priority: reset=0 and D toggling every cycle for 4 edges
//      -> Q equals RESET_VAL after every edge. Assertions never fire.

Source files
------------

// File: rtl/common_pkg.sv
// Shared definitions for the synchronous-reset storage primitives.
package common_pkg;

    // Level of a reset input. A named type keeps polarity comparisons
    // readable wherever a sync-reset primitive tests its reset pin.
    typedef logic rst_pol_t;

    // All sync-reset primitives in this library reset while the input is low.
    localparam rst_pol_t RST_ACTIVE   = 1'b0;
    localparam rst_pol_t RST_INACTIVE = ~RST_ACTIVE;

    // Returns 1 only for a clean, known asserted level. X or Z returns 0,
    // so a caller can still tell an unknown level from a known one.
    function automatic logic rst_is_active(input rst_pol_t level);
        return (level === RST_ACTIVE);
    endfunction

    // Returns 1 only for a clean, known released level.
    function automatic logic rst_is_inactive(input rst_pol_t level);
        return (level === RST_INACTIVE);
    endfunction

endpackage

// File: rtl/dff_bit_sync_rstn.sv
// One-bit D flop with synchronous active-low reset and a per-cell reset value.
module dff_bit_sync_rstn
    import common_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    // Reset is sampled only at the clock edge and wins over d. An unknown
    // reset level makes q unknown rather than quietly choosing a branch.
    always_ff @(posedge clk) begin
        if (rst_is_active(reset)) begin
            q <= RESET_VAL;
        end else if (rst_is_inactive(reset)) begin
            q <= d;
        end else begin
            q <= 1'bx;
        end
    end

endmodule

// File: rtl/dff_sync_rstn.sv
// WIDTH-bit D register with synchronous active-low reset, built from 1-bit cells.
// Q comes straight from the cell flops with no combinational path to the output.
module dff_sync_rstn
    import common_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // One cell per bit. Each cell takes its own bit of RESET_VAL.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_bit_sync_rstn #(
            .RESET_VAL (RESET_VAL[i])
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .d     (D[i]),
            .q     (Q[i])
        );
    end

`ifndef SYNTHESIS
    // Masks the $past checks until one edge of history exists.
    logic past_valid = 1'b0;

    // Marks the first edge so the checks below have a valid previous sample.
    always_ff @(posedge clk) begin
        past_valid <= 1'b1;
    end

    a_reset_loads : assert property (
        @(posedge clk) (past_valid && rst_is_active($past(reset))) |-> (Q == RESET_VAL)
    ) else $error("dff_sync_rstn: Q != RESET_VAL one edge after reset");

    a_capture_d : assert property (
        @(posedge clk) (past_valid && rst_is_inactive($past(reset))) |-> (Q == $past(D))
    ) else $error("dff_sync_rstn: Q != D from previous edge");
`endif

endmodule

// File: tb/tb_dff_sync_rstn.sv
// Self-checking bench for dff_sync_rstn: a narrow 1-bit instance and a wide 8-bit one.
module tb_dff_sync_rstn;

    localparam logic [7:0] WIDE_RV = 8'hA5;

    logic       clk = 1'b0;
    logic       rst1, rst8;
    logic [0:0] d1, q1;
    logic [7:0] d8, q8;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    dff_sync_rstn #(.WIDTH(1)) u_narrow (
        .clk   (clk),
        .reset (rst1),
        .D     (d1),
        .Q     (q1)
    );

    dff_sync_rstn #(.WIDTH(8), .RESET_VAL(WIDE_RV)) u_wide (
        .clk   (clk),
        .reset (rst8),
        .D     (d8),
        .Q     (q8)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    endtask

    typedef struct {
        logic       r1;
        logic       v1;
        logic [0:0] e1;
        logic       r8;
        logic [7:0] v8;
        logic [7:0] e8;
    } vec_t;

    vec_t vecs[$];

    // Expected register value after an edge, straight from the behavioural rule.
    function automatic logic [7:0] ref_q(input logic r, input logic [7:0] dv, input logic [7:0] rv);
        return r ? dv : rv;
    endfunction

    initial begin
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 8'hA5});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 8'h3C});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hA5});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hA5});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hA5});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 8'h5A});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h12, 8'hA5});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 8'h81, 8'h81});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 8'hC3, 8'hC3});

        // Timed scenario on the narrow instance; the wide one is held in reset.
        rst1 = 1'b0; d1 = 1'b0; rst8 = 1'b0; d8 = 8'h00;
        #6  check("hold_e5",  q1, 1'b0);
        check("wide_rst_e5", q8, WIDE_RV);
        #4  d1 = 1'b1;
        #6  check("hold_e15_over_d1", q1, 1'b0);
        #4  rst1 = 1'b1; d1 = 1'b0;
        #6  check("release_e25", q1, 1'b0);
        #14 d1 = 1'b1;
        #6  check("capture_e45", q1, 1'b1);
        #10 check("held_e55", q1, 1'b1);
        #4  rst1 = 1'b0; d1 = 1'b0;
        #2  check("midcycle_rst_no_effect", q1, 1'b1);
        #4  check("sync_rst_e65", q1, 1'b0);
        #4  d1 = 1'b1;
        #6  check("rst_e75_over_d1", q1, 1'b0);
        #10 check("rst_e85_over_d1", q1, 1'b0);
        #6  rst1 = 1'b1; d1 = 1'b1;
        #1  check("midcycle_release_no_effect", q1, 1'b0);
        #3  check("release_e95", q1, 1'b1);

        // Table-driven vectors: drive on falling edge, check just after rising.
        foreach (vecs[i]) begin
            @(negedge clk);
            rst1 = vecs[i].r1; d1 = vecs[i].v1;
            rst8 = vecs[i].r8; d8 = vecs[i].v8;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_narrow", i), q1, vecs[i].e1);
            check($sformatf("vec%0d_wide", i), q8, vecs[i].e8);
        end

        // Random stimulus against the reference rule, with D glitches between edges.
        for (int n = 0; n < 200; n++) begin
            logic [7:0] exp1, exp8;
            @(negedge clk);
            rst1 = ($urandom_range(0, 4) != 0);
            rst8 = ($urandom_range(0, 4) != 0);
            d1   = 1'($urandom);
            d8   = 8'($urandom);
            exp1 = ref_q(rst1, {7'b0, d1}, 8'h00);
            exp8 = ref_q(rst8, d8, WIDE_RV);
            @(posedge clk);
            #1;
            check("rand_narrow", q1, exp1);
            check("rand_wide", q8, exp8);
            d1 = ~d1;
            d8 = ~d8;
            #2;
            check("glitch_narrow", q1, exp1);
            check("glitch_wide", q8, exp8);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Safety net so a stalled run still ends with a verdict.
    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish before 50000");
        $fatal(1, "timeout");
    end

endmodule
